// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: tagless direct-mapped table of 2-bit counters and targets,
// trained by the execute stage, with a registered one-cycle mispredict redirect.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid_in,
    input  logic [31:0] if_pc_in,
    output logic        pred_taken_out,
    output logic [31:0] pred_target_out,
    input  logic        ex_branch_en_in,
    input  logic [31:0] ex_pc_in,
    input  logic        ex_is_compressed_in,
    input  logic        ex_taken_in,
    input  logic [31:0] ex_target_in,
    input  logic        ex_pred_taken_in,
    input  logic [31:0] ex_pred_target_in,
    output logic        mispredict_out,
    output logic [31:0] redirect_pc_out
);

    logic [1:0]  counter [ENTRIES];
    logic        valid   [ENTRIES];
    logic [31:0] target  [ENTRIES];

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] update_idx;
    logic [1:0]       counter_next;
    logic             mis;
    logic [31:0]      redirect_next;

    // Index is halfword-granular so compressed branches get their own slots.
    assign lookup_idx = if_pc_in[IDX_W:1];
    assign update_idx = ex_pc_in[IDX_W:1];

    always_comb begin
        pred_taken_out  = if_valid_in & valid[lookup_idx] & counter[lookup_idx][1];
        pred_target_out = pred_taken_out ? target[lookup_idx] : if_pc_in + 32'd4;
    end

    always_comb begin
        counter_next = counter[update_idx];
        if (ex_taken_in) begin
            if (counter[update_idx] != 2'b11) counter_next = counter[update_idx] + 2'b01;
        end else begin
            if (counter[update_idx] != 2'b00) counter_next = counter[update_idx] - 2'b01;
        end
    end

    always_comb begin
        mis = ex_branch_en_in &
              ((ex_taken_in != ex_pred_taken_in) |
               (ex_taken_in & ex_pred_taken_in & (ex_target_in != ex_pred_target_in)));
        redirect_next = ex_taken_in ? ex_target_in
                                    : ex_pc_in + (ex_is_compressed_in ? 32'd2 : 32'd4);
    end

    // NOTE: the whole table is reset (not just valid bits) so a mid-run reset leaves
    // every entry in a known weakly-not-taken state; this forces flops rather than RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counter[i] <= 2'b01;
                valid[i]   <= 1'b0;
                target[i]  <= 32'd0;
            end
        end else if (ex_branch_en_in) begin
            // NOTE: non-blocking writes keep same-cycle lookups seeing the pre-update entry.
            counter[update_idx] <= counter_next;
            if (ex_taken_in) begin
                target[update_idx] <= ex_target_in;
                valid[update_idx]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_out  <= 1'b0;
            redirect_pc_out <= 32'd0;
        end else begin
            mispredict_out <= mis;
            if (mis) redirect_pc_out <= redirect_next;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: table-driven vectors with a scoreboard queue
// for the registered redirect outputs, plus a hand-written mid-operation reset sequence.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid_in;
    logic [31:0] if_pc_in;
    logic        pred_taken_out;
    logic [31:0] pred_target_out;
    logic        ex_branch_en_in;
    logic [31:0] ex_pc_in;
    logic        ex_is_compressed_in;
    logic        ex_taken_in;
    logic [31:0] ex_target_in;
    logic        ex_pred_taken_in;
    logic [31:0] ex_pred_target_in;
    logic        mispredict_out;
    logic [31:0] redirect_pc_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        if_valid;
        logic [31:0] if_pc;
        logic        en;
        logic [31:0] pc;
        logic        comp;
        logic        taken;
        logic [31:0] tgt;
        logic        ptaken;
        logic [31:0] ptgt;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_mis;
        logic [31:0] e_redir;
    } vec_t;

    typedef struct {
        logic        mis;
        logic [31:0] redir;
    } reg_exp_t;

    vec_t     vecs [$];
    reg_exp_t sb   [$];

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .if_valid_in         (if_valid_in),
        .if_pc_in            (if_pc_in),
        .pred_taken_out      (pred_taken_out),
        .pred_target_out     (pred_target_out),
        .ex_branch_en_in     (ex_branch_en_in),
        .ex_pc_in            (ex_pc_in),
        .ex_is_compressed_in (ex_is_compressed_in),
        .ex_taken_in         (ex_taken_in),
        .ex_target_in        (ex_target_in),
        .ex_pred_taken_in    (ex_pred_taken_in),
        .ex_pred_target_in   (ex_pred_target_in),
        .mispredict_out      (mispredict_out),
        .redirect_pc_out     (redirect_pc_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic iv, input logic [31:0] ipc,
        input logic en, input logic [31:0] pc, input logic comp, input logic tk,
        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
        input logic etk, input logic [31:0] etgt, input logic emis, input logic [31:0] eredir);
        vec_t v;
        v.if_valid = iv;  v.if_pc = ipc;
        v.en = en;  v.pc = pc;  v.comp = comp;  v.taken = tk;  v.tgt = tgt;
        v.ptaken = ptk;  v.ptgt = ptgt;
        v.e_taken = etk;  v.e_target = etgt;  v.e_mis = emis;  v.e_redir = eredir;
        return v;
    endfunction

    task automatic drive_idle();
        if_valid_in = 1'b0;  if_pc_in = 32'd0;
        ex_branch_en_in = 1'b0;  ex_pc_in = 32'd0;  ex_is_compressed_in = 1'b0;
        ex_taken_in = 1'b0;  ex_target_in = 32'd0;
        ex_pred_taken_in = 1'b0;  ex_pred_target_in = 32'd0;
    endtask

    // Drive one cycle, check the combinational lookup mid-cycle, queue the expected
    // registered result, then pop and compare it just after the clock edge.
    task automatic apply(input vec_t v, input int n);
        reg_exp_t e;
        if_valid_in = v.if_valid;  if_pc_in = v.if_pc;
        ex_branch_en_in = v.en;  ex_pc_in = v.pc;  ex_is_compressed_in = v.comp;
        ex_taken_in = v.taken;  ex_target_in = v.tgt;
        ex_pred_taken_in = v.ptaken;  ex_pred_target_in = v.ptgt;
        sb.push_back('{mis: v.e_mis, redir: v.e_redir});
        @(negedge clk);
        check($sformatf("v%0d pred_taken", n), {31'd0, pred_taken_out}, {31'd0, v.e_taken});
        check($sformatf("v%0d pred_target", n), pred_target_out, v.e_target);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d mispredict", n), {31'd0, mispredict_out}, {31'd0, e.mis});
        check($sformatf("v%0d redirect", n), redirect_pc_out, e.redir);
    endtask

    initial begin
        // iv  if_pc         en  pc            c  tk  tgt    ptk ptgt    | e_tk e_tgt        mis redir
        vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0));
        vecs.push_back(mk(1, 32'h100, 1, 32'h100, 0, 1, 32'h200, 0, 32'h0,   0, 32'h104, 1, 32'h200));
        vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h200));
        vecs.push_back(mk(1, 32'h100, 1, 32'h100, 0, 1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h200));
        vecs.push_back(mk(1, 32'h100, 1, 32'h100, 0, 1, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h200));
        vecs.push_back(mk(1, 32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h200, 1, 32'h200, 1, 32'h104));
        vecs.push_back(mk(1, 32'h100, 1, 32'h100, 0, 0, 32'h0,   1, 32'h200, 1, 32'h200, 1, 32'h104));
        vecs.push_back(mk(1, 32'h100, 1, 32'h100, 0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104));
        vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104));
        vecs.push_back(mk(0, 32'h3FE, 1, 32'h3FE, 1, 0, 32'h0,   1, 32'h500, 0, 32'h402, 1, 32'h400));
        vecs.push_back(mk(0, 32'hFFFFFFFC, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0,  0, 32'h0,   0, 32'h400));
        vecs.push_back(mk(0, 32'h0,   1, 32'hFFFFFFFC, 0, 0, 32'h0, 1, 32'h8, 0, 32'h4,   1, 32'h0));
        vecs.push_back(mk(1, 32'h500, 1, 32'h500, 0, 1, 32'h340, 1, 32'h300, 0, 32'h504, 1, 32'h340));
        vecs.push_back(mk(1, 32'h500, 1, 32'h500, 0, 1, 32'h340, 1, 32'h340, 0, 32'h504, 0, 32'h340));
        vecs.push_back(mk(1, 32'h100, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h340, 0, 32'h340));
        vecs.push_back(mk(0, 32'h0,   1, 32'h600, 0, 1, 32'h700, 0, 32'h0,   0, 32'h4,   1, 32'h700));
        vecs.push_back(mk(0, 32'h0,   1, 32'h800, 1, 0, 32'h0,   1, 32'h900, 0, 32'h4,   1, 32'h802));
        vecs.push_back(mk(1, 32'h600, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   1, 32'h700, 0, 32'h802));

        rst_n = 1'b0;
        drive_idle();
        #2;
        check("reset mispredict", {31'd0, mispredict_out}, 32'd0);
        check("reset redirect", redirect_pc_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        check("scoreboard drained", sb.size(), 32'd0);

        // Mid-operation reset while a mispredict pulse is live.
        if_valid_in = 1'b1;  if_pc_in = 32'h100;
        ex_branch_en_in = 1'b1;  ex_pc_in = 32'h100;  ex_taken_in = 1'b1;
        ex_target_in = 32'h900;  ex_pred_taken_in = 1'b0;  ex_pred_target_in = 32'h0;
        @(posedge clk);
        #1;
        check("pre-reset pulse", {31'd0, mispredict_out}, 32'd1);
        check("pre-reset redirect", redirect_pc_out, 32'h900);
        rst_n = 1'b0;
        ex_branch_en_in = 1'b0;
        #1;
        check("async clear mispredict", {31'd0, mispredict_out}, 32'd0);
        check("async clear redirect", redirect_pc_out, 32'd0);
        check("in-reset lookup 0x100 taken", {31'd0, pred_taken_out}, 32'd0);
        check("in-reset lookup 0x100 target", pred_target_out, 32'h104);
        if_pc_in = 32'h600;
        #1;
        check("in-reset lookup 0x600 taken", {31'd0, pred_taken_out}, 32'd0);
        check("in-reset lookup 0x600 target", pred_target_out, 32'h604);
        @(negedge clk);
        rst_n = 1'b1;
        if_pc_in = 32'h100;
        @(posedge clk);
        #1;
        check("post-reset lookup taken", {31'd0, pred_taken_out}, 32'd0);
        check("post-reset mispredict", {31'd0, mispredict_out}, 32'd0);

        // One taken update from the reset state (01 -> 10) is enough to predict taken.
        ex_branch_en_in = 1'b1;  ex_pc_in = 32'h100;  ex_taken_in = 1'b1;
        ex_target_in = 32'hA00;  ex_pred_taken_in = 1'b1;  ex_pred_target_in = 32'hA00;
        @(posedge clk);
        #1;
        ex_branch_en_in = 1'b0;
        check("retrain no pulse", {31'd0, mispredict_out}, 32'd0);
        #1;
        check("retrain lookup taken", {31'd0, pred_taken_out}, 32'd1);
        check("retrain lookup target", pred_target_out, 32'hA00);
        if_valid_in = 1'b0;
        #1;
        check("invalid fetch not taken", {31'd0, pred_taken_out}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
